// File: rtl/tile_dispatch_scheduler.sv
// tile_dispatch_scheduler: walks an image in BLK x BLK tiles in raster order,
// hands each tile to one of N_ENG identical engines by round-robin, counts
// completions and pulses img_done once every tile has been processed.
module tile_dispatch_scheduler #(
  parameter int IMG_H = 480,
  parameter int IMG_W = 640,
  parameter int BLK   = 8,
  parameter int N_ENG = 2,
  localparam int TR = IMG_H / BLK,
  localparam int TC = IMG_W / BLK,
  localparam int NT = TR * TC,
  localparam int RW = $clog2(TR),
  localparam int CW = $clog2(TC),
  localparam int NW = $clog2(NT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_img,
  input  logic [N_ENG-1:0] eng_done,
  output logic [N_ENG-1:0] eng_start,
  output logic [RW-1:0]    eng_row,
  output logic [CW-1:0]    eng_col,
  output logic             busy,
  output logic             img_done,
  output logic [NW-1:0]    tiles_issued,
  output logic [NW-1:0]    tiles_done,
  output logic             err
);

  localparam int EW = (N_ENG > 1) ? $clog2(N_ENG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [N_ENG-1:0] owned;
  logic [EW-1:0]    rr;
  logic [RW-1:0]    row_ptr;
  logic [CW-1:0]    col_ptr;
  logic             grant_vld;
  logic [EW-1:0]    grant_idx;
  logic [N_ENG-1:0] grant_oh;
  logic [N_ENG-1:0] done_ok;
  logic [N_ENG-1:0] done_bad;
  logic             last_tile;
  logic             accept_start;

  // Engine index k steps past the round-robin pointer, wrapped to N_ENG.
  function automatic int rr_idx(input int base, input int k);
    return (base + k) % N_ENG;
  endfunction

  assign accept_start = (state == S_IDLE) && start_img;
  // A done only counts when that engine actually holds a tile.
  assign done_ok      = eng_done & owned;
  assign done_bad     = eng_done & ~owned;
  assign last_tile    = (tiles_issued == NW'(NT - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (start_img) state_nx = S_DISPATCH;
      S_DISPATCH: if (grant_vld && last_tile) state_nx = S_DRAIN;
      S_DRAIN:    if (tiles_done == NW'(NT)) state_nx = S_DONE;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Grant selection: first free engine searching from rr; ownership is the
  // registered view, so an engine freed on this edge is not reused on it.
  always_comb begin
    logic [EW-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    idx       = '0;
    if (state == S_DISPATCH) begin
      for (int k = 0; k < N_ENG; k++) begin
        idx = EW'(rr_idx(int'(rr), k));
        if (!grant_vld && !owned[idx]) begin
          grant_vld     = 1'b1;
          grant_idx     = idx;
          grant_oh[idx] = 1'b1;
        end
      end
    end
  end

  // Datapath and registered outputs: grants, pointers, ownership, counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_start    <= '0;
      eng_row      <= '0;
      eng_col      <= '0;
      busy         <= 1'b0;
      img_done     <= 1'b0;
      tiles_issued <= '0;
      tiles_done   <= '0;
      err          <= 1'b0;
      owned        <= '0;
      rr           <= '0;
      row_ptr      <= '0;
      col_ptr      <= '0;
    end else begin
      eng_start  <= grant_oh;
      busy       <= (state_nx != S_IDLE);
      img_done   <= (state == S_DONE);
      owned      <= (owned & ~done_ok) | grant_oh;
      tiles_done <= tiles_done + NW'($countones(done_ok));
      if (|done_bad) err <= 1'b1;

      if (grant_vld) begin
        eng_row      <= row_ptr;
        eng_col      <= col_ptr;
        rr           <= EW'(rr_idx(int'(grant_idx), 1));
        tiles_issued <= tiles_issued + NW'(1);
        if (col_ptr == CW'(TC - 1)) begin
          col_ptr <= '0;
          row_ptr <= row_ptr + RW'(1);
        end else begin
          col_ptr <= col_ptr + CW'(1);
        end
      end

      // A new image wipes all per-image bookkeeping, including a pending err.
      if (accept_start) begin
        tiles_issued <= '0;
        tiles_done   <= '0;
        err          <= 1'b0;
        owned        <= '0;
        rr           <= '0;
        row_ptr      <= '0;
        col_ptr      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tile_dispatch_scheduler.sv
// Testbench for tile_dispatch_scheduler: 16x24 image, 8x8 tiles, 2 engines.
// Stimulus pushes hand-computed grant and img_done records; a monitor pops
// and compares them whenever the DUT presents eng_start or img_done.
module tb_tile_dispatch_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_img;
  logic [1:0] model_done;
  logic [1:0] spur_done;
  logic [1:0] eng_done;
  logic [1:0] eng_start;
  logic [0:0] eng_row;
  logic [1:0] eng_col;
  logic       busy;
  logic       img_done;
  logic [2:0] tiles_issued;
  logic [2:0] tiles_done;
  logic       err;

  assign eng_done = model_done | spur_done;

  tile_dispatch_scheduler #(
    .IMG_H(16), .IMG_W(24), .BLK(8), .N_ENG(2)
  ) dut (
    .clk(clk), .rst(rst), .start_img(start_img), .eng_done(eng_done),
    .eng_start(eng_start), .eng_row(eng_row), .eng_col(eng_col),
    .busy(busy), .img_done(img_done), .tiles_issued(tiles_issued),
    .tiles_done(tiles_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int eng;
    int row;
    int col;
    int cyc;
    int issued;
  } grant_t;

  grant_t grant_q[$];
  int     done_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     lat [2];

  // Hand-computed schedules, cycle offsets relative to the start_img edge.
  // 0: both engines latency 3; 1: engine 1 latency 20; 2: latencies 4/3.
  localparam int ENG_TAB [3][6] = '{'{0,1,0,1,0,1}, '{0,1,0,0,0,0}, '{0,1,0,1,0,1}};
  localparam int OFF_TAB [3][6] = '{'{1,2,6,7,11,12}, '{1,2,6,11,16,21}, '{1,2,7,8,13,14}};
  localparam int DONE_OFF [3]   = '{18, 27, 20};
  localparam int LAT_TAB [3][2] = '{'{3,3}, '{3,20}, '{4,3}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0d, expected none", name, act);
  endtask

  // Engine model: eng_done pulses in the cycle lat[i] cycles after eng_start.
  initial begin
    int cnt [2];
    cnt = '{0, 0};
    model_done = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cnt = '{0, 0};
        model_done = '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          model_done[i] = 1'b0;
          if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) model_done[i] = 1'b1;
          end
          if (eng_start[i]) cnt[i] = lat[i];
        end
      end
    end
  end

  // Monitor: pops expected records on eng_start / img_done and compares.
  initial begin
    grant_t     g;
    logic [1:0] held;
    logic [1:0] prev_done;
    logic [1:0] exp_oh;
    int         last_done_cyc;
    int         e;
    held = '0;
    prev_done = '0;
    last_done_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = '0;
        prev_done = '0;
      end else begin
        if (eng_start != 2'b00) begin
          if (grant_q.size() == 0) begin
            fail_now("unexpected_grant", int'(eng_start));
          end else begin
            g = grant_q.pop_front();
            exp_oh = '0;
            exp_oh[g.eng] = 1'b1;
            check("grant_eng", eng_start, exp_oh);
            check("grant_row", eng_row, g.row);
            check("grant_col", eng_col, g.col);
            check("grant_cycle", cyc, g.cyc);
            check("grant_issued", tiles_issued, g.issued);
          end
          for (int i = 0; i < 2; i++)
            if (eng_start[i]) check("grant_to_owned_engine", held[i], 0);
        end
        for (int i = 0; i < 2; i++) begin
          if (prev_done[i]) held[i] = 1'b0;
          if (eng_start[i]) held[i] = 1'b1;
        end
        prev_done = eng_done;
        if (eng_done != 2'b00) last_done_cyc = cyc;
        if (img_done) begin
          if (done_q.size() == 0) begin
            fail_now("unexpected_img_done", cyc);
          end else begin
            e = done_q.pop_front();
            check("img_done_cycle", cyc, e);
            check("img_done_after_last_done", cyc - last_done_cyc, 3);
            check("final_tiles_done", tiles_done, 6);
            check("final_tiles_issued", tiles_issued, 6);
            check("busy_at_img_done", busy, 0);
            check("err_at_img_done", err, 0);
          end
        end
      end
    end
  end

  // Start one image using schedule t; pushes the first n_grants records.
  task automatic run_image(input int t, input int n_grants, input bit want_done, output int k);
    grant_t g;
    lat[0] = LAT_TAB[t][0];
    lat[1] = LAT_TAB[t][1];
    @(negedge clk);
    start_img = 1'b1;
    @(posedge clk);
    #1;
    start_img = 1'b0;
    k = cyc;
    check("busy_after_start", busy, 1);
    check("issued_cleared", tiles_issued, 0);
    check("done_cleared", tiles_done, 0);
    check("err_cleared", err, 0);
    for (int i = 0; i < n_grants; i++) begin
      g.eng    = ENG_TAB[t][i];
      g.row    = i / 3;
      g.col    = i % 3;
      g.cyc    = k + OFF_TAB[t][i];
      g.issued = i + 1;
      grant_q.push_back(g);
    end
    if (want_done) done_q.push_back(k + DONE_OFF[t]);
  endtask

  // Wait (bounded) for all expected records; optional extra start_img pulse
  // while busy and the simultaneous-done counter probe.
  task automatic wait_image(input int k, input bit dup_start, input bit chk_pair);
    for (int i = 0; i < 100 && (grant_q.size() != 0 || done_q.size() != 0); i++) begin
      @(posedge clk);
      #1;
      start_img = dup_start && (cyc == k + 3);
      if (chk_pair && cyc == k + 5) check("pair_done_before", tiles_done, 0);
      if (chk_pair && cyc == k + 6) check("pair_done_after", tiles_done, 2);
    end
    start_img = 1'b0;
    if (grant_q.size() != 0) fail_now("timeout_grants_left", grant_q.size());
    if (done_q.size() != 0) fail_now("timeout_img_done_left", done_q.size());
    grant_q.delete();
    done_q.delete();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    start_img = 1'b0;
    spur_done = '0;
    lat = '{3, 3};
    #12;
    check("reset_outputs",
          {eng_start, eng_row, eng_col, busy, img_done, tiles_issued, tiles_done, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic run and latency: alternating engines, raster tiles.
    run_image(0, 6, 1'b1, k);
    wait_image(k, 1'b0, 1'b0);

    // Backpressure: engine 1 held for 20 cycles, engine 0 takes the rest.
    run_image(1, 6, 1'b1, k);
    wait_image(k, 1'b0, 1'b0);

    // Simultaneous dones from both engines.
    run_image(2, 6, 1'b1, k);
    wait_image(k, 1'b0, 1'b1);

    // Spurious done in IDLE sets sticky err; next start clears it.
    @(posedge clk);
    #1;
    spur_done = 2'b10;
    @(posedge clk);
    #1;
    spur_done = 2'b00;
    check("spurious_err_set", err, 1);
    check("spurious_no_count", tiles_done, 6);
    repeat (3) @(posedge clk);
    #1;
    check("spurious_err_sticky", err, 1);
    run_image(0, 6, 1'b1, k);
    wait_image(k, 1'b0, 1'b0);

    // Reset after three grants, then a clean image with an ignored start.
    run_image(0, 3, 1'b0, k);
    repeat (6) @(posedge clk);
    #6;
    rst = 1'b1;
    #1;
    check("midreset_outputs",
          {eng_start, eng_row, eng_col, busy, img_done, tiles_issued, tiles_done, err}, 0);
    check("midreset_grants_seen", grant_q.size(), 0);
    grant_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    run_image(0, 6, 1'b1, k);
    wait_image(k, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
